// File: rtl/axi_tg_pkg.sv
// Shared types, AXI constants and helpers for the burst traffic generator.
package axi_tg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_WR_RESP = 3'd3;
  localparam state_t ST_RD_ADDR = 3'd4;
  localparam state_t ST_RD_DATA = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WR_RD   = 2'b00;
  localparam mode_t MODE_WR_ONLY = 2'b01;
  localparam mode_t MODE_RD_ONLY = 2'b10;
  localparam mode_t MODE_ALIAS   = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// Combinational data pattern: 32-bit lane i of beat n is seed + n*lanes + i.
module axi_tg_pattern #(
  parameter int unsigned DataWidth = 32
) (
  input  logic [31:0]          seed_i,
  input  logic [31:0]          beat_i,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned Lanes = DataWidth / 32;

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      data_o[i*32 +: 32] = seed_i + beat_i * 32'(Lanes) + 32'(i);
    end
  end

endmodule

// File: rtl/axi_burst_traffic_gen.sv
// AXI4 master that writes a seeded incrementing pattern in bursts, reads it back and
// counts response, data and RLAST errors.
module axi_burst_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned C_NUM_BURSTS       = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 32'h4000_0000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  input  logic [31:0]                     SEED,
  output logic                            BUSY,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [15:0]                     ERR_COUNT,
  output logic [C_M_AXI_ID_WIDTH-1:0]     AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]                      AWLEN,
  output logic [2:0]                      AWSIZE,
  output logic [1:0]                      AWBURST,
  output logic                            AWLOCK,
  output logic [3:0]                      AWCACHE,
  output logic [2:0]                      AWPROT,
  output logic [3:0]                      AWQOS,
  output logic                            AWVALID,
  input  logic                            AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                            WLAST,
  output logic                            WVALID,
  input  logic                            WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     BID,
  input  logic [1:0]                      BRESP,
  input  logic                            BVALID,
  output logic                            BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]                      ARLEN,
  output logic [2:0]                      ARSIZE,
  output logic [1:0]                      ARBURST,
  output logic                            ARLOCK,
  output logic [3:0]                      ARCACHE,
  output logic [2:0]                      ARPROT,
  output logic [3:0]                      ARQOS,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                      RRESP,
  input  logic                            RLAST,
  input  logic                            RVALID,
  output logic                            RREADY
);

  localparam int unsigned BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES    = C_M_AXI_BURST_LEN * BYTES_PER_BEAT;
  localparam logic [7:0]  LAST_BEAT      = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [9:0]  LAST_BURST     = 10'(C_NUM_BURSTS - 1);
  localparam logic [2:0]  AX_SIZE        = 3'(clog2(BYTES_PER_BEAT));
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);

  if (BURST_BYTES > 4096) begin : g_chk_burst_bytes
    $error("burst byte size exceeds 4096");
  end
  if ((C_TARGET_BASE_ADDR % ADDR_STEP) != '0) begin : g_chk_base_align
    $error("base address not aligned to the burst byte size");
  end
  if (C_M_AXI_DATA_WIDTH != 32 && C_M_AXI_DATA_WIDTH != 64 && C_M_AXI_DATA_WIDTH != 128)
  begin : g_chk_data_width
    $error("data width must be 32, 64 or 128");
  end
  if (C_M_AXI_BURST_LEN < 1 || C_M_AXI_BURST_LEN > 256 || C_NUM_BURSTS < 1 ||
      C_NUM_BURSTS > 1024) begin : g_chk_counts
    $error("burst length or burst count out of range");
  end

  state_t                          state_q;
  mode_t                           mode_q;
  logic [31:0]                     seed_q;
  logic [31:0]                     w_beat_q;
  logic [31:0]                     r_beat_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                      beat_q;
  logic [9:0]                      burst_q;
  logic [1:0]                      init_q;
  logic                            error_q;
  logic [15:0]                     err_count_q;

  logic                            start;
  mode_t                           start_mode;
  logic                            b_hs;
  logic                            r_hs;
  logic                            beat_last;
  logic                            burst_last;
  logic [1:0]                      err_events;
  logic [16:0]                     err_sum;
  logic [15:0]                     err_count_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_pattern;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rd_expected;
  logic                            unused_ids;

  axi_tg_pattern #(
    .DataWidth (C_M_AXI_DATA_WIDTH)
  ) u_wr_pattern (
    .seed_i (seed_q),
    .beat_i (w_beat_q),
    .data_o (wr_pattern)
  );

  axi_tg_pattern #(
    .DataWidth (C_M_AXI_DATA_WIDTH)
  ) u_rd_pattern (
    .seed_i (seed_q),
    .beat_i (r_beat_q),
    .data_o (rd_expected)
  );

  // init_q[0] is the synchroniser stage; a start is one cycle of 0->1 between stages.
  assign start = init_q[0] & ~init_q[1] & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign start_mode = (MODE == MODE_ALIAS) ? MODE_WR_RD : MODE;
  assign b_hs = (state_q == ST_WR_RESP) & BVALID;
  assign r_hs = (state_q == ST_RD_DATA) & RVALID;
  assign beat_last  = (beat_q == LAST_BEAT);
  assign burst_last = (burst_q == LAST_BURST);
  assign unused_ids = ^{BID, RID};

  // B and R handshakes never coincide, so at most three events arrive per cycle.
  always_comb begin
    err_events = 2'd0;
    if (b_hs && (BRESP != RESP_OKAY)) err_events = err_events + 2'd1;
    if (r_hs) begin
      if (RRESP != RESP_OKAY)   err_events = err_events + 2'd1;
      if (RDATA != rd_expected) err_events = err_events + 2'd1;
      if (RLAST != beat_last)   err_events = err_events + 2'd1;
    end
    err_sum     = {1'b0, err_count_q} + {15'd0, err_events};
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WR_RD;
      seed_q      <= '0;
      w_beat_q    <= '0;
      r_beat_q    <= '0;
      addr_q      <= C_TARGET_BASE_ADDR;
      beat_q      <= '0;
      burst_q     <= '0;
      init_q      <= 2'b00;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      init_q <= {init_q[0], INIT_AXI_TXN};
      if (err_events != 2'd0) begin
        error_q     <= 1'b1;
        err_count_q <= err_count_d;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            error_q     <= 1'b0;
            err_count_q <= '0;
            mode_q      <= start_mode;
            seed_q      <= SEED;
            w_beat_q    <= '0;
            r_beat_q    <= '0;
            addr_q      <= C_TARGET_BASE_ADDR;
            beat_q      <= '0;
            burst_q     <= '0;
            state_q     <= (start_mode == MODE_RD_ONLY) ? ST_RD_ADDR : ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (AWREADY) begin
            beat_q  <= '0;
            state_q <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (WREADY) begin
            beat_q   <= beat_q + 8'd1;
            w_beat_q <= w_beat_q + 32'd1;
            if (beat_last) state_q <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            if (burst_last) begin
              burst_q <= '0;
              addr_q  <= C_TARGET_BASE_ADDR;
              state_q <= (mode_q == MODE_WR_ONLY) ? ST_DONE : ST_RD_ADDR;
            end else begin
              burst_q <= burst_q + 10'd1;
              addr_q  <= addr_q + ADDR_STEP;
              state_q <= ST_WR_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (ARREADY) begin
            beat_q  <= '0;
            state_q <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (RVALID) begin
            beat_q   <= beat_q + 8'd1;
            r_beat_q <= r_beat_q + 32'd1;
            // Burst ends on the beat count so a missing RLAST cannot stall the run.
            if (beat_last) begin
              if (burst_last) begin
                burst_q <= '0;
                addr_q  <= C_TARGET_BASE_ADDR;
                state_q <= ST_DONE;
              end else begin
                burst_q <= burst_q + 10'd1;
                addr_q  <= addr_q + ADDR_STEP;
                state_q <= ST_RD_ADDR;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign TXN_DONE  = (state_q == ST_DONE);
  assign ERROR     = error_q;
  assign ERR_COUNT = err_count_q;

  assign AWID    = '0;
  assign AWADDR  = addr_q;
  assign AWLEN   = LAST_BEAT;
  assign AWSIZE  = AX_SIZE;
  assign AWBURST = BURST_INCR;
  assign AWLOCK  = 1'b0;
  assign AWCACHE = CACHE_MODIFIABLE;
  assign AWPROT  = 3'b000;
  assign AWQOS   = 4'b0000;
  assign AWVALID = (state_q == ST_WR_ADDR);

  assign WDATA  = wr_pattern;
  assign WSTRB  = '1;
  assign WVALID = (state_q == ST_WR_DATA);
  assign WLAST  = (state_q == ST_WR_DATA) && beat_last;

  assign BREADY = (state_q == ST_WR_RESP);

  assign ARID    = '0;
  assign ARADDR  = addr_q;
  assign ARLEN   = LAST_BEAT;
  assign ARSIZE  = AX_SIZE;
  assign ARBURST = BURST_INCR;
  assign ARLOCK  = 1'b0;
  assign ARCACHE = CACHE_MODIFIABLE;
  assign ARPROT  = 3'b000;
  assign ARQOS   = 4'b0000;
  assign ARVALID = (state_q == ST_RD_ADDR);

  assign RREADY = (state_q == ST_RD_DATA);

endmodule

// File: doc/axi_burst_traffic_gen.md
# axi_burst_traffic_gen

Parametrised AXI4 full-master burst traffic generator and checker. On a start pulse it writes `C_NUM_BURSTS` incrementing bursts of a seeded pattern to a target slave, reads them back and compares them. It reports a done flag, an error flag and an error count. It replaces the fixed single-mode example master and sits directly on an AXI4 master port, typically facing a VIP slave or a memory controller.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, address width.
- `C_M_AXI_DATA_WIDTH`, 32, data width: 32, 64 or 128.
- `C_M_AXI_ID_WIDTH`, 1, ID width; ID is driven as 0.
- `C_M_AXI_BURST_LEN`, 16, beats per burst, 1..256.
- `C_NUM_BURSTS`, 4, bursts per run, 1..1024.
- `C_TARGET_BASE_ADDR`, 32'h4000_0000, first burst address; must be aligned to the burst byte size.
- `M_AXI_ACLK` in 1: single clock; all logic on the rising edge.
- `M_AXI_ARESET` in 1: synchronous, active-high reset.
- `INIT_AXI_TXN` in 1: start request; the rising edge is detected internally.
- `MODE` in 2: sampled at start.
  - 00: write then read-compare.
  - 01: write only.
  - 10: read-compare only.
  - 11: treated as 00.
- `SEED` in 32: pattern seed, sampled at start.
- `BUSY` out 1: run in progress.
- `TXN_DONE` out 1: level; set at run end, cleared at the next start.
- `ERROR` out 1: sticky for the run; cleared at the next start.
- `ERR_COUNT` out 16: errors in the run, saturating at 16'hFFFF.
- AW channel, out: `AWID`, `AWADDR`, `AWLEN`, `AWSIZE`, `AWBURST`=INCR, `AWLOCK`=0, `AWCACHE`=4'b0010, `AWPROT`=0, `AWQOS`=0, `AWVALID`. In: `AWREADY`.
- W channel, out: `WDATA`, `WSTRB` (all ones), `WLAST`, `WVALID`. In: `WREADY`.
- B channel, in: `BID`, `BRESP`, `BVALID`. Out: `BREADY`.
- AR channel, out: `ARID`, `ARADDR`, `ARLEN`, `ARSIZE`, `ARBURST`, `ARLOCK`, `ARCACHE`, `ARPROT`, `ARQOS`, `ARVALID`; same constants as AW. In: `ARREADY`.
- R channel, in: `RID`, `RDATA`, `RRESP`, `RLAST`, `RVALID`. Out: `RREADY`.

## Operation
- FSM states: `IDLE`, `WR_ADDR`, `WR_DATA`, `WR_RESP`, `RD_ADDR`, `RD_DATA`, `DONE`.
- Start: an `INIT_AXI_TXN` edge in `IDLE` or `DONE` clears `TXN_DONE`, `ERROR` and `ERR_COUNT`, latches `MODE` and `SEED`, and goes to `WR_ADDR` (`RD_ADDR` for mode 10). Edges while `BUSY` are ignored.
- Burst address: burst k uses `C_TARGET_BASE_ADDR + k*C_M_AXI_BURST_LEN*(C_M_AXI_DATA_WIDTH/8)`, modulo 2^ADDR_WIDTH.
- Length fields: `AxLEN = C_M_AXI_BURST_LEN-1`; `AxSIZE = log2(DATA_WIDTH/8)`.
- Data pattern: global beat index n counts across all bursts. Each 32-bit lane i of beat n is `SEED + n*(DATA_WIDTH/32) + i`, mod 2^32.
- Write phase: one outstanding burst. Sequence is `WR_ADDR`, then `WR_DATA` (`WLAST` on beat `BURST_LEN-1`), then `WR_RESP`. After the last burst go to `RD_ADDR` (mode 00) or `DONE` (mode 01).
- Read phase: one outstanding burst. Sequence is `RD_ADDR`, then `RD_DATA`; each beat is compared to the pattern. After the last burst go to `DONE`.
- Error events each add one to `ERR_COUNT` and set `ERROR`:
  - `BRESP`≠0.
  - `RRESP`≠0.
  - Data mismatch.
  - `RLAST` present but wrong, checked per beat.
- Reset mid-run: all VALID/READY outputs drop, FSM to `IDLE`, flags cleared. The slave is assumed reset by the same reset.

## Timing
- Reset values: all VALIDs 0, `BREADY`/`RREADY` 0, `BUSY` 0, `TXN_DONE` 0, `ERROR` 0, `ERR_COUNT` 0, `AxADDR` = base.
- Start latency: `AWVALID` (or `ARVALID`) rises 2 cycles after the `INIT_AXI_TXN` rising edge (edge register plus state register).
- `AxVALID` stays high until `AxREADY`; address and length stay stable while VALID is high.
- `WVALID` rises the cycle after the AW handshake. One beat per cycle when `WREADY` is held high; `WDATA` advances only on a handshake.
- `BREADY` is high only in `WR_RESP`; `RREADY` is high only in `RD_DATA`. The next burst's `AxVALID` rises the cycle after the B handshake or the `RLAST` handshake.
- Compare is registered: `ERR_COUNT` updates 1 cycle after the offending handshake. `TXN_DONE` rises 1 cycle after the last handshake, so that final compare is included.
- An error and the final handshake in the same cycle are both counted.

## Structure
- Package `axi_tg_pkg`: state enum, mode enum, `RESP_OKAY` constant, and a `clog2` helper for `AxSIZE`.
- Sub-module `axi_tg_pattern`: combinational lane pattern from (seed, beat index). It is instantiated twice: once for W data and once for the R expected value.
- Elaboration asserts:
  - Burst size in bytes ≤ 4096.
  - Base address aligned to the burst size.
  - `C_M_AXI_DATA_WIDTH` is 32, 64 or 128.

## Test plan
- Mode 00, defaults, `SEED`=0, VIP slave ready always: 64 write beats then 64 read beats, `TXN_DONE`=1, `ERROR`=0, `ERR_COUNT`=0. Beat 5 `WDATA` = 32'h5.
- DATA_WIDTH 128, BURST_LEN 256, 2 bursts, `SEED`=32'h1000: the second `AWADDR` is base+0x1000. Beat 1 `WDATA` = {32'h1007, 32'h1006, 32'h1005, 32'h1004}.
- Slave injects `BRESP`=2'b10 on burst 2 and corrupts read beat 3: `ERR_COUNT`=2, `ERROR`=1.
- Random `AWREADY`/`WREADY`/`ARREADY` backpressure at 50 % with `RVALID` gaps: no data loss, VALIDs stable under stall, `ERR_COUNT`=0.
- Pulse `M_AXI_ARESET` during beat 7 of write burst 1, then restart: all VALIDs 0 next cycle, run completes clean. A second `INIT_AXI_TXN` pulse while `BUSY` is ignored.
- Mode 10 after a mode-01 run with the same `SEED`: 0 errors. Repeat with `SEED`+1: 64 errors.
